booth_mul_pipe: RTL
===================

Name: booth_mul_pipe

Overview:
- Parametrised, pipelined radix-4 Booth multiplier with a selectable signed/unsigned mode per transaction.
- Successor to the combinational 24x24 unsigned Booth/Wallace multiplier, for use as the FP mantissa multiplier and as a general integer multiplier.
- Fixed 3-stage pipeline with valid/ready handshakes on input and output, plus full backpressure.

Parameters:
- WIDTH, 24, operand width in bits; legal range 4..64, odd values allowed.
- NDIG, localparam = (WIDTH+2)/2 (integer division), number of radix-4 Booth digits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block accepts operands this cycle.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- in_signed  in  1  1 = two's-complement operands; 0 = unsigned.
- out_valid  out  1  product present.
- out_ready  in  1  consumer accepts product.
- out_p  out  2*WIDTH  product.
- out_signed  out  1  in_signed of the transaction carried alongside the result.

Behaviour:
- Accept and transfer rules:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Operand extension: operands are extended to WIDTH+2 bits, sign-extended if in_signed = 1 and zero-extended if in_signed = 0.
- Booth recoding: in_b is recoded into NDIG digits in {-2,-1,0,+1,+2} using overlapping triplets with an implicit 0 below bit 0.
  - There is no separate correction row; the zero-extension covers unsigned operands.
- S1 (register): encode digits and generate partial products.
  - Each row is extended in_a times digit, WIDTH+3 bits.
  - Negation is done as one's complement plus a neg bit injected at the row LSB.
  - Rows are sign-extended to 2*WIDTH bits.
- S2 (register): carry-save compression of all rows plus neg bits down to two 2*WIDTH-bit vectors (sum, carry).
- S3 (register): final carry-propagate add, modulo 2^(2*WIDTH). The result is exact for both modes.
- Latency: exactly 3 cycles from input transfer to out_valid with no stall. Throughput is 1 per cycle.
- Pipeline stalls:
  - stall = out_valid && !out_ready.
  - in_ready = !stall, combinational from out_ready and the S3 valid bit.
  - On stall, all stages hold their data and valid bits. No bubble-collapsing.
- When not stalled, each stage's valid bit takes the upstream valid bit. A bubble (valid = 0) propagates as a bubble, and its data is don't-care.
- out_p and out_signed hold stable while out_valid && !out_ready.
- Reset:
  - All valid bits clear to 0, so out_valid = 0.
  - out_p = 0, out_signed = 0. Datapath registers reset to 0.
  - in_ready = 1 during and after reset.
- Reset asserted mid-operation drops all in-flight transactions with no output. The first transfer after deassertion produces its result 3 cycles later.
- Simultaneous accept and drain in the same cycle is legal and sustains full rate.
- in_signed is sampled only at input transfer. Changing it on non-transfer cycles has no effect.

Optional Feature:
- Macro: BOOTH_MUL_PIPE_STICKY_EN.
- Defined: adds output port out_sticky (1 bit), registered with S3.
  - out_sticky = OR of out_p[WIDTH-2:0]. This is the round/sticky source for the FP mantissa path.
  - Resets to 0 and holds under stall like out_p.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Decomposition:
- Package booth_mul_pkg holds:
  - typedef booth_dig_t, a 3-bit one-hot {neg, x1, x2} digit encoding.
  - function booth_enc(triplet) returning booth_dig_t.
  - constant BOOTH_STAGES = 3.
- Sub-module booth_pp_gen: one digit encode plus partial-product row (extended multiplicand, triplet -> row, neg bit). It is instantiated NDIG times in S1.
- The CSA tree stays inline as a generate loop of 3:2 compressors.

Test Plan (WIDTH=24):
- Unsigned full scale: a=0xFFFFFF, b=0xFFFFFF, in_signed=0 -> out_p=0xFFFFFE000001, out_valid exactly 3 cycles after accept.
- Signed extremes:
  - 0x800000 * 0x800000, in_signed=1 -> 0x400000000000.
  - 0xFFFFFF * 0x000001, in_signed=1 -> 0xFFFFFFFFFFFF.
  - Same operands with in_signed=0 -> 0x000000FFFFFF.
- Streaming with backpressure: 100 back-to-back random transfers with out_ready toggled randomly -> results match a reference model in order, none lost or duplicated, out_p stable while stalled, in_ready=0 exactly when out_valid && !out_ready.
- Reset mid-flight: accept 2 transactions, assert rst_n=0 one cycle later -> out_valid=0, out_p=0 immediately. Accept 0x000002 * 0x000003 after release -> 0x6 after 3 cycles.
- Sticky (macro defined):
  - 0x800000 * 0x000003 unsigned -> out_p=0x1800000, out_sticky=0.
  - 0x800001 * 0x000001 unsigned -> out_sticky=1.
- Parameter sweep: WIDTH=4 and WIDTH=7, exhaustive over all operand pairs in both modes -> all products exact.

Source files
------------

// File: rtl/booth_mul_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier.
// The digit encoding is one-hot on magnitude, with a separate sign flag.
package booth_mul_pkg;

    localparam int unsigned BOOTH_STAGES = 3;

    typedef struct packed {
        logic neg;
        logic x1;
        logic x2;
    } booth_dig_t;

    // Map a multiplier triplet {b[2i+1], b[2i], b[2i-1]} to a Booth digit.
    // Both 000 and 111 encode 0. Each of them returns all flags clear.
    function automatic booth_dig_t booth_enc(input logic [2:0] trip);
        booth_dig_t d;
        d = '0;
        case (trip)
            3'b001, 3'b010: d.x1 = 1'b1;
            3'b011:         d.x2 = 1'b1;
            3'b100:         begin d.neg = 1'b1; d.x2 = 1'b1; end
            3'b101, 3'b110: begin d.neg = 1'b1; d.x1 = 1'b1; end
            default:        ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/booth_pp_gen.sv
// One Booth digit: encode the triplet and form its partial-product row.
// Negative digits produce the one's complement. The +1 comes from neg,
// which is added at the row LSB.
module booth_pp_gen
    import booth_mul_pkg::*;
#(
    parameter int unsigned WIDTH = 24
) (
    input  logic [WIDTH+1:0] a_ext,
    input  logic [2:0]       trip,
    output logic [WIDTH+2:0] row,
    output logic             neg
);

    booth_dig_t       dig;
    logic [WIDTH+2:0] mag;

    // Select 0, a or 2a, then conditionally invert.
    always_comb begin
        dig = booth_enc(trip);
        mag = '0;
        if (dig.x1)
            mag = {a_ext[WIDTH+1], a_ext};
        else if (dig.x2)
            mag = {a_ext, 1'b0};
        row = dig.neg ? ~mag : mag;
        neg = dig.neg;
    end

endmodule

// File: rtl/booth_mul_pipe.sv
// Pipelined radix-4 Booth multiplier, signed or unsigned per transaction.
// S1: partial products, S2: carry-save reduction, S3: final add.
// Optional: define BOOTH_MUL_PIPE_STICKY_EN to add out_sticky = |out_p[WIDTH-2:0].
module booth_mul_pipe
    import booth_mul_pkg::*;
#(
    parameter int unsigned WIDTH = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p,
    output logic               out_signed
`ifdef BOOTH_MUL_PIPE_STICKY_EN
    ,
    output logic               out_sticky
`endif
);

    localparam int unsigned NDIG = (WIDTH + 2) / 2;
    localparam int unsigned PW   = 2 * WIDTH;
    localparam int unsigned NROW = NDIG + 1;

    logic                    stall;
    logic [BOOTH_STAGES-1:0] vld;

    // Operand extension. For odd WIDTH, one extension bit is enough to
    // cover the top triplet of b, so b is only padded to 2*NDIG bits.
    logic [WIDTH+1:0]  a_ext;
    logic [2*NDIG-1:0] b_ext;
    logic [2*NDIG:0]   b_pad;

    assign a_ext = {{2{in_signed & in_a[WIDTH-1]}}, in_a};
    assign b_ext = {{(2*NDIG-WIDTH){in_signed & in_b[WIDTH-1]}}, in_b};
    assign b_pad = {b_ext, 1'b0};

    logic [WIDTH+2:0] pp_row [NDIG];
    logic [NDIG-1:0]  pp_neg;
    logic [PW-1:0]    pp_ext [NDIG];
    logic [PW-1:0]    neg_row;

    for (genvar i = 0; i < NDIG; i++) begin : g_pp
        booth_pp_gen #(.WIDTH(WIDTH)) u_pp (
            .a_ext (a_ext),
            .trip  (b_pad[2*i+2:2*i]),
            .row   (pp_row[i]),
            .neg   (pp_neg[i])
        );
        assign pp_ext[i] = {{(PW-WIDTH-3){pp_row[i][WIDTH+2]}}, pp_row[i]} << (2*i);
    end

    // The neg bits sit at distinct even positions. They are therefore
    // packed into one extra row instead of being handled separately.
    always_comb begin
        neg_row = '0;
        for (int unsigned i = 0; i < NDIG; i++)
            neg_row[2*i] = pp_neg[i];
    end

    assign stall     = vld[BOOTH_STAGES-1] & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = vld[BOOTH_STAGES-1];

    // Valid bits advance together. On a stall, every stage holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld <= '0;
        else if (!stall)
            vld <= {vld[BOOTH_STAGES-2:0], in_valid};
    end

    logic [PW-1:0] s1_rows [NROW];
    logic          s1_signed;

    // S1: register the partial-product rows.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NROW; i++)
                s1_rows[i] <= '0;
            s1_signed <= 1'b0;
        end else if (!stall) begin
            for (int unsigned i = 0; i < NDIG; i++)
                s1_rows[i] <= pp_ext[i];
            s1_rows[NDIG] <= neg_row;
            s1_signed     <= in_signed;
        end
    end

    // Carry-save array. Each 3:2 compressor folds one more row into (sum, carry).
    logic [PW-1:0] cs_sum [NROW-1];
    logic [PW-1:0] cs_cry [NROW-1];

    assign cs_sum[0] = s1_rows[0];
    assign cs_cry[0] = s1_rows[1];

    for (genvar k = 0; k < NROW - 2; k++) begin : g_csa
        assign cs_sum[k+1] = cs_sum[k] ^ cs_cry[k] ^ s1_rows[k+2];
        assign cs_cry[k+1] = {(cs_sum[k][PW-2:0] & cs_cry[k][PW-2:0])
                            | (cs_sum[k][PW-2:0] & s1_rows[k+2][PW-2:0])
                            | (cs_cry[k][PW-2:0] & s1_rows[k+2][PW-2:0]), 1'b0};
    end

    logic [PW-1:0] s2_sum;
    logic [PW-1:0] s2_cry;
    logic          s2_signed;

    // S2: register the reduced sum/carry pair.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_sum    <= '0;
            s2_cry    <= '0;
            s2_signed <= 1'b0;
        end else if (!stall) begin
            s2_sum    <= cs_sum[NROW-2];
            s2_cry    <= cs_cry[NROW-2];
            s2_signed <= s1_signed;
        end
    end

    logic [PW-1:0] p_sum;
    assign p_sum = s2_sum + s2_cry;

    // S3: final carry-propagate add, modulo 2^(2*WIDTH).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_p      <= '0;
            out_signed <= 1'b0;
        end else if (!stall) begin
            out_p      <= p_sum;
            out_signed <= s2_signed;
        end
    end

`ifdef BOOTH_MUL_PIPE_STICKY_EN
    // Sticky bit for mantissa rounding. It is registered alongside out_p.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            out_sticky <= 1'b0;
        else if (!stall)
            out_sticky <= |p_sum[WIDTH-2:0];
    end
`endif

endmodule
